// File: rtl/alu_exec_mem_if.sv
// Operand, control and memory signals for the execute/memory slice.
// The master drives operands and control; the slave returns ALU and read data.
interface alu_exec_mem_if;
    logic [1:0]  i_ALUOp;
    logic [2:0]  i_Funct3;
    logic [6:0]  i_Funct7;
    logic [31:0] i_Op1;
    logic [31:0] i_Op2;
    logic        i_MemRead;
    logic        i_MemWrite;
    logic [31:0] i_Wd;
    logic [3:0]  o_ALUControlLines;
    logic [31:0] o_Result;
    logic        o_Zero;
    logic [31:0] o_Rd;

    modport master (
        output i_ALUOp, i_Funct3, i_Funct7, i_Op1, i_Op2,
        output i_MemRead, i_MemWrite, i_Wd,
        input  o_ALUControlLines, o_Result, o_Zero, o_Rd
    );

    modport slave (
        input  i_ALUOp, i_Funct3, i_Funct7, i_Op1, i_Op2,
        input  i_MemRead, i_MemWrite, i_Wd,
        output o_ALUControlLines, o_Result, o_Zero, o_Rd
    );
endinterface

// File: rtl/alu_exec_mem.sv
// RV32I execute/memory slice: ALU-control decode, 32-bit ALU and a
// word-addressed data memory whose address is the ALU result.
module alu_exec_mem #(
    parameter int DM_DEPTH  = 64,
    parameter int WORD_SIZE = 32
) (
    input logic          i_clk,
    input logic          i_rst_n,
    alu_exec_mem_if.slave bus
);
    localparam int AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLTU = 4'b1000,
        OP_SRA  = 4'b1001
    } alu_op_e;

    alu_op_e               w_ctrl;
    logic [WORD_SIZE-1:0]  w_a;
    logic [WORD_SIZE-1:0]  w_b;
    logic [4:0]            w_shamt;
    logic [WORD_SIZE-1:0]  w_result;
    logic                  w_alt;
    logic [AW-1:0]         w_idx;
    logic                  w_in_range;
    logic                  w_unused;
    logic [WORD_SIZE-1:0]  r_mem [DM_DEPTH];

    assign w_alt    = bus.i_Funct7[5];
    assign w_unused = &{1'b0, bus.i_Funct7[6], bus.i_Funct7[4:0]};

    always_comb begin
        w_ctrl = OP_ADD;
        unique case (bus.i_ALUOp)
            2'b00: w_ctrl = OP_ADD;
            2'b01: w_ctrl = OP_SUB;
            default: begin
                unique case (bus.i_Funct3)
                    3'b000: w_ctrl = (bus.i_ALUOp == 2'b10 && w_alt)
                                     ? OP_SUB : OP_ADD;
                    3'b001: w_ctrl = OP_SLL;
                    3'b010: w_ctrl = OP_SLT;
                    3'b011: w_ctrl = OP_SLTU;
                    3'b100: w_ctrl = OP_XOR;
                    3'b101: w_ctrl = w_alt ? OP_SRA : OP_SRL;
                    3'b110: w_ctrl = OP_OR;
                    3'b111: w_ctrl = OP_AND;
                    default: w_ctrl = OP_ADD;
                endcase
            end
        endcase
    end

    assign w_a     = bus.i_Op1;
    assign w_b     = bus.i_Op2;
    assign w_shamt = bus.i_Op2[4:0];

    always_comb begin
        w_result = '0;
        case (w_ctrl)
            OP_AND:  w_result = w_a & w_b;
            OP_OR:   w_result = w_a | w_b;
            OP_ADD:  w_result = w_a + w_b;
            OP_XOR:  w_result = w_a ^ w_b;
            OP_SLL:  w_result = w_a << w_shamt;
            OP_SRL:  w_result = w_a >> w_shamt;
            OP_SUB:  w_result = w_a - w_b;
            OP_SLT:  w_result = {31'd0, $signed(w_a) < $signed(w_b)};
            OP_SLTU: w_result = {31'd0, w_a < w_b};
            OP_SRA:  w_result = $unsigned($signed(w_a) >>> w_shamt);
            default: w_result = '0;
        endcase
    end

    assign bus.o_ALUControlLines = w_ctrl;
    assign bus.o_Result          = w_result;
    assign bus.o_Zero            = (w_result == '0);

    // Byte offset bits [1:0] are ignored; any set bit above the index is out of range.
    assign w_idx      = w_result[AW+1:2];
    assign w_in_range = (w_result[WORD_SIZE-1:AW+2] == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.i_MemWrite && w_in_range) begin
            r_mem[w_idx] <= bus.i_Wd;
        end
    end

    assign bus.o_Rd = (bus.i_MemRead && w_in_range) ? r_mem[w_idx] : '0;

endmodule

// File: tb/tb_alu_exec_mem.sv
// Directed self-checking bench for alu_exec_mem.
// Each task drives one scenario and compares against hand-computed values.
module tb_alu_exec_mem;
    localparam int DEPTH = 64;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_exec_mem_if bus ();

    alu_exec_mem #(.DM_DEPTH(DEPTH), .WORD_SIZE(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    task automatic drive(input logic [1:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a,
                         input logic [31:0] b);
        bus.i_ALUOp  = op;
        bus.i_Funct3 = f3;
        bus.i_Funct7 = f7;
        bus.i_Op1    = a;
        bus.i_Op2    = b;
        #1;
    endtask

    task automatic run_table(input string tag, input vec_t v [$]);
        foreach (v[k]) begin
            drive(v[k].op, v[k].f3, v[k].f7, v[k].a, v[k].b);
            checks++;
            if (bus.o_Result !== v[k].res) begin
                failures++;
                $display("FAIL %s[%0d] result got=%h exp=%h",
                         tag, k, bus.o_Result, v[k].res);
            end
            checks++;
            if (bus.o_ALUControlLines !== v[k].ctrl) begin
                failures++;
                $display("FAIL %s[%0d] ctrl got=%b exp=%b",
                         tag, k, bus.o_ALUControlLines, v[k].ctrl);
            end
            checks++;
            if (bus.o_Zero !== v[k].zero) begin
                failures++;
                $display("FAIL %s[%0d] zero got=%b exp=%b",
                         tag, k, bus.o_Zero, v[k].zero);
            end
        end
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp);
        drive(2'b00, 3'b000, 7'h00, addr, 32'd0);
        checks++;
        if (bus.o_Rd !== exp) begin
            failures++;
            $display("FAIL %s addr=%h rd got=%h exp=%h", tag, addr, bus.o_Rd, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] d);
        @(negedge clk);
        drive(2'b00, 3'b000, 7'h00, addr, 32'd0);
        bus.i_Wd       = d;
        bus.i_MemWrite = 1'b1;
        @(posedge clk);
        #1;
        bus.i_MemWrite = 1'b0;
    endtask

    task automatic test_reset;
        bus.i_MemRead = 1'b1;
        read_chk("reset_rd0", 32'h0, 32'h0);
        read_chk("reset_rd_top", 32'(4*(DEPTH-1)), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        read_chk("post_reset_rd", 32'h14, 32'h0);
        bus.i_MemRead = 1'b0;
    endtask

    task automatic test_decode;
        vec_t v [$];
        v.push_back('{2'b10, 3'b000, 7'h00, 32'd7, 32'd5, 4'b0010, 32'd12, 1'b0});
        v.push_back('{2'b10, 3'b000, 7'h20, 32'd7, 32'd5, 4'b0110, 32'd2, 1'b0});
        v.push_back('{2'b10, 3'b111, 7'h00, 32'd7, 32'd5, 4'b0000, 32'd5, 1'b0});
        v.push_back('{2'b10, 3'b110, 7'h00, 32'd7, 32'd5, 4'b0001, 32'd7, 1'b0});
        v.push_back('{2'b10, 3'b100, 7'h00, 32'd7, 32'd5, 4'b0011, 32'd2, 1'b0});
        v.push_back('{2'b11, 3'b000, 7'h20, 32'd7, 32'd5, 4'b0010, 32'd12, 1'b0});
        v.push_back('{2'b10, 3'b000, 7'h5f, 32'd7, 32'd7, 4'b0010, 32'd14, 1'b0});
        v.push_back('{2'b00, 3'b111, 7'h20, 32'd7, 32'd5, 4'b0010, 32'd12, 1'b0});
        v.push_back('{2'b10, 3'b000, 7'h20, 32'd5, 32'd5, 4'b0110, 32'd0, 1'b1});
        run_table("decode", v);
    endtask

    task automatic test_shift_cmp;
        vec_t v [$];
        v.push_back('{2'b10, 3'b101, 7'h00, 32'h80000000, 32'd4, 4'b0101, 32'h08000000, 1'b0});
        v.push_back('{2'b10, 3'b101, 7'h20, 32'h80000000, 32'd4, 4'b1001, 32'hF8000000, 1'b0});
        v.push_back('{2'b11, 3'b101, 7'h20, 32'h80000000, 32'h24, 4'b1001, 32'hF8000000, 1'b0});
        v.push_back('{2'b10, 3'b101, 7'h00, 32'h80000000, 32'h24, 4'b0101, 32'h08000000, 1'b0});
        v.push_back('{2'b11, 3'b001, 7'h00, 32'h1, 32'h24, 4'b0100, 32'h10, 1'b0});
        v.push_back('{2'b10, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 4'b0111, 32'd1, 1'b0});
        v.push_back('{2'b10, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1, 4'b1000, 32'd0, 1'b1});
        v.push_back('{2'b11, 3'b011, 7'h00, 32'd1, 32'hFFFFFFFF, 4'b1000, 32'd1, 1'b0});
        run_table("shift_cmp", v);
    endtask

    task automatic test_branch;
        vec_t v [$];
        v.push_back('{2'b01, 3'b000, 7'h00, 32'h1234, 32'h1234, 4'b0110, 32'h0, 1'b1});
        v.push_back('{2'b01, 3'b000, 7'h00, 32'h1234, 32'h1235, 4'b0110, 32'hFFFFFFFF, 1'b0});
        v.push_back('{2'b00, 3'b000, 7'h00, 32'hFFFFFFFF, 32'd1, 4'b0010, 32'h0, 1'b1});
        run_table("branch", v);
    endtask

    task automatic test_store_load;
        @(negedge clk);
        drive(2'b00, 3'b000, 7'h00, 32'h10, 32'd4);
        bus.i_Wd       = 32'hDEADBEEF;
        bus.i_MemWrite = 1'b1;
        bus.i_MemRead  = 1'b1;
        #1;
        checks++;
        if (bus.o_Rd !== 32'h0) begin
            failures++;
            $display("FAIL store_pre_edge rd got=%h exp=%h", bus.o_Rd, 32'h0);
        end
        @(posedge clk);
        #1;
        bus.i_MemWrite = 1'b0;
        read_chk("load_same", 32'h14, 32'hDEADBEEF);
        read_chk("load_unaligned", 32'h17, 32'hDEADBEEF);
        read_chk("load_neighbour", 32'h18, 32'h0);
        bus.i_MemRead = 1'b0;
        read_chk("load_no_memread", 32'h14, 32'h0);
    endtask

    task automatic test_boundaries;
        write_word(32'(4*(DEPTH-1)), 32'hA5A50001);
        write_word(32'(4*DEPTH), 32'h12345678);
        bus.i_MemRead = 1'b1;
        read_chk("bound_top", 32'(4*(DEPTH-1)), 32'hA5A50001);
        read_chk("bound_oob", 32'(4*DEPTH), 32'h0);
        read_chk("bound_no_alias", 32'h0, 32'h0);
        read_chk("bound_high_bit", 32'h80000014, 32'h0);
        bus.i_MemRead = 1'b0;
    endtask

    task automatic test_back_to_back;
        write_word(32'h0, 32'h11111111);
        @(negedge clk);
        drive(2'b00, 3'b000, 7'h00, 32'h0, 32'h0);
        bus.i_Wd       = 32'hFFFFFFFF;
        bus.i_MemWrite = 1'b1;
        bus.i_MemRead  = 1'b1;
        #1;
        checks++;
        if (bus.o_Rd !== 32'h11111111) begin
            failures++;
            $display("FAIL rw_old rd got=%h exp=%h", bus.o_Rd, 32'h11111111);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.o_Rd !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL rw_new rd got=%h exp=%h", bus.o_Rd, 32'hFFFFFFFF);
        end
        bus.i_MemWrite = 1'b0;
        bus.i_MemRead  = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] fill [4];
        fill = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        for (int k = 0; k < 4; k++) write_word(32'(4*k), fill[k]);
        bus.i_MemRead = 1'b1;
        read_chk("fill_w2", 32'h8, 32'hC2C2C2C2);
        @(negedge clk);
        drive(2'b00, 3'b000, 7'h00, 32'h4, 32'h0);
        bus.i_Wd       = 32'hCAFE0001;
        bus.i_MemWrite = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) read_chk("rst_clear", 32'(4*k), 32'h0);
        read_chk("rst_clear_top", 32'(4*(DEPTH-1)), 32'h0);
        drive(2'b00, 3'b000, 7'h00, 32'h4, 32'h0);
        @(posedge clk);
        #1;
        read_chk("rst_blocks_write", 32'h4, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_MemWrite = 1'b0;
        read_chk("post_rel_w1", 32'h4, 32'h0);
        write_word(32'h8, 32'h00000077);
        read_chk("post_rel_write", 32'h8, 32'h00000077);
        read_chk("post_rel_w0", 32'h0, 32'h0);
        bus.i_MemRead = 1'b0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.i_ALUOp    = 2'b00;
        bus.i_Funct3   = 3'b000;
        bus.i_Funct7   = 7'h00;
        bus.i_Op1      = 32'h0;
        bus.i_Op2      = 32'h0;
        bus.i_MemRead  = 1'b0;
        bus.i_MemWrite = 1'b0;
        bus.i_Wd       = 32'h0;
        #2;
        test_reset();
        test_decode();
        test_shift_cmp();
        test_branch();
        test_store_load();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
